// File: rtl/iq_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_accumulator_pkg
// Desc     : Shared defaults, FSM state type and packed-output field layout
//            for the IQ accumulator and its downstream normalizer.
// Revision : 1.0 - initial release
// ============================================================================
package iq_accumulator_pkg;

  localparam int c_in_width_def  = 16;
  localparam int c_acc_width_def = 32;
  localparam int c_len_width_def = 12;

  // Field positions of {sumI, sumQ} in accumulated_output at default widths
  localparam int c_out_i_msb = 2*c_acc_width_def - 1;
  localparam int c_out_i_lsb = c_acc_width_def;
  localparam int c_out_q_msb = c_acc_width_def - 1;
  localparam int c_out_q_lsb = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_EMIT  = 2'd3
  } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/iq_acc_channel.sv
`default_nettype none
// ============================================================================
// Module   : iq_acc_channel
// Desc     : Signed clear/enable accumulator for one I or Q channel.
// Revision : 1.0 - initial release
// ============================================================================
module iq_acc_channel
  import iq_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = c_in_width_def,
  parameter int ACC_WIDTH = c_acc_width_def
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  sample,
  output logic signed [ACC_WIDTH-1:0] sum
);

  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] r_sum;

  assign w_ext = {{(ACC_WIDTH-IN_WIDTH){sample[IN_WIDTH-1]}}, sample};

  // Plain two's-complement wrap; no saturation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= r_sum + w_ext;
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/iq_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : iq_accumulator
// Desc     : Triggered IQ window accumulator: skips delay_len valid samples,
//            sums win_len valid samples, then strobes the packed result.
// Revision : 1.0 - initial release
// ============================================================================
module iq_accumulator
  import iq_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = c_in_width_def,
  parameter int ACC_WIDTH = c_acc_width_def,
  parameter int LEN_WIDTH = c_len_width_def
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trigger,
  input  logic [LEN_WIDTH-1:0]        delay_len,
  input  logic [LEN_WIDTH-1:0]        win_len,
  input  logic                        adc_valid,
  input  logic signed [IN_WIDTH-1:0]  adc_i,
  input  logic signed [IN_WIDTH-1:0]  adc_q,
  output logic [2*ACC_WIDTH-1:0]      accumulated_output,
  output logic                        stb_start,
  output logic                        busy
);

  acc_state_e                  r_state;
  acc_state_e                  w_next_state;
  logic [LEN_WIDTH-1:0]        r_skip_cnt;
  logic [LEN_WIDTH-1:0]        r_win_cnt;
  logic                        w_clear;
  logic                        w_acc_en;
  logic                        w_skip_last;
  logic                        w_win_last;
  logic signed [ACC_WIDTH-1:0] w_sum_i;
  logic signed [ACC_WIDTH-1:0] w_sum_q;

  assign w_skip_last = adc_valid && (r_skip_cnt == LEN_WIDTH'(1));
  assign w_win_last  = adc_valid && (r_win_cnt  == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (trigger) begin
          if (delay_len != '0)      w_next_state = ST_SKIP;
          else if (win_len != '0)   w_next_state = ST_ACCUM;
          else                      w_next_state = ST_EMIT;
        end
      end
      ST_SKIP: begin
        if (w_skip_last) begin
          w_next_state = (r_win_cnt != '0) ? ST_ACCUM : ST_EMIT;
        end
      end
      ST_ACCUM: begin
        if (w_win_last) w_next_state = ST_EMIT;
      end
      ST_EMIT:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    w_clear  = (r_state == ST_IDLE) && trigger;
    w_acc_en = (r_state == ST_ACCUM) && adc_valid;
  end

  // Lengths are captured only on an accepted trigger, so later port changes are harmless
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
      r_win_cnt  <= '0;
    end else if (w_clear) begin
      r_skip_cnt <= delay_len;
      r_win_cnt  <= win_len;
    end else if ((r_state == ST_SKIP) && adc_valid) begin
      r_skip_cnt <= r_skip_cnt - LEN_WIDTH'(1);
    end else if (w_acc_en) begin
      r_win_cnt  <= r_win_cnt - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accumulated_output <= '0;
      stb_start          <= 1'b0;
    end else begin
      stb_start <= (r_state == ST_EMIT);
      if (r_state == ST_EMIT) begin
        accumulated_output <= {w_sum_i, w_sum_q};
      end
    end
  end

  iq_acc_channel #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_chan_i (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_clear),
    .en     (w_acc_en),
    .sample (adc_i),
    .sum    (w_sum_i)
  );

  iq_acc_channel #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_chan_q (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_clear),
    .en     (w_acc_en),
    .sample (adc_q),
    .sum    (w_sum_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_iq_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_accumulator
// Desc     : Scoreboard bench for iq_accumulator window/timing behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_accumulator;
  import iq_accumulator_pkg::*;

  localparam int IW = c_in_width_def;
  localparam int AW = c_acc_width_def;
  localparam int LW = c_len_width_def;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 trigger;
  logic [LW-1:0]        delay_len;
  logic [LW-1:0]        win_len;
  logic                 adc_valid;
  logic signed [IW-1:0] adc_i;
  logic signed [IW-1:0] adc_q;
  logic [2*AW-1:0]      acc_out;
  logic                 stb_start;
  logic                 busy;

  typedef struct {
    logic [2*AW-1:0] data;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  logic [2*AW-1:0] model_out = '0;
  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;

  iq_accumulator #(
    .IN_WIDTH  (IW),
    .ACC_WIDTH (AW),
    .LEN_WIDTH (LW)
  ) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .trigger            (trigger),
    .delay_len          (delay_len),
    .win_len            (win_len),
    .adc_valid          (adc_valid),
    .adc_i              (adc_i),
    .adc_q              (adc_q),
    .accumulated_output (acc_out),
    .stb_start          (stb_start),
    .busy               (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; returns #1 after the edge that samples it
  task automatic step(input logic trig, input int d, input int w,
                      input logic v, input int i, input int q);
    trigger   = trig;
    delay_len = LW'(d);
    win_len   = LW'(w);
    adc_valid = v;
    adc_i     = IW'(i);
    adc_q     = IW'(q);
    @(posedge clk);
    #1;
    trigger   = 1'b0;
    adc_valid = 1'b0;
  endtask

  task automatic trig(input int d, input int w);
    step(1'b1, d, w, 1'b0, 0, 0);
  endtask

  task automatic sample(input int i, input int q);
    step(1'b0, 0, 0, 1'b1, i, q);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  // Called right after the edge that completes a window: strobe is due one edge later
  task automatic push_exp(input int si, input int sq);
    exp_t e;
    e.data = {32'(si), 32'(sq)};
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    idle();
    idle();
    idle();
  endtask

  always @(negedge clk) begin
    if (stb_start) begin
      if (sb.size() == 0) begin
        check_eq("stray_stb", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("acc_out", acc_out, mon_e.data);
        check_eq("stb_cyc", 64'(cyc), 64'(mon_e.cyc));
        model_out <= mon_e.data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    trigger = 1'b0; delay_len = '0; win_len = '0;
    adc_valid = 1'b0; adc_i = '0; adc_q = '0;
    repeat (3) idle();
    check_eq("rst_out",  acc_out, 64'd0);
    check_eq("rst_stb",  64'(stb_start), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    idle();

    // delay 2, window 4; skipped samples carry large values that must not leak in
    trig(2, 4);
    check_eq("busy_run", 64'(busy), 64'd1);
    sample(999, 999);
    sample(999, 999);
    repeat (3) sample(100, -50);
    sample(100, -50);
    push_exp(400, -200);
    drain();
    check_eq("busy_after", 64'(busy), 64'd0);

    // gaps in adc_valid must not count or sum
    trig(0, 3);
    sample(1, 4);
    step(1'b0, 0, 0, 1'b0, 77, 77);
    sample(2, 5);
    step(1'b0, 0, 0, 1'b0, 55, 55);
    sample(3, 6);
    push_exp(6, 15);
    drain();

    // full-scale 2048-sample window
    trig(0, 2048);
    for (int k = 0; k < 2048; k++) sample(-32768, 32767);
    push_exp(-67108864, 67106816);
    drain();

    // delay only, zero window; skip counter holds across an invalid cycle
    trig(2, 0);
    sample(7, 7);
    idle();
    sample(8, 8);
    push_exp(0, 0);
    drain();

    // triggers during ACCUM and during EMIT are both ignored
    trig(1, 3);
    sample(900, 900);
    sample(10, 20);
    check_eq("hold_out", acc_out, model_out);
    step(1'b1, 0, 1, 1'b1, 30, 40);
    sample(50, 60);
    push_exp(90, 120);
    trig(0, 0);
    drain();
    check_eq("busy_ign", 64'(busy), 64'd0);

    // reset mid-window aborts; first trigger right after release is accepted
    trig(0, 4);
    sample(11, 11);
    sample(12, 12);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    check_eq("mid_rst_out",  acc_out, 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_stb",  64'(stb_start), 64'd0);
    trig(0, 1);
    sample(5, 0);
    push_exp(5, 0);
    drain();

    // zero delay, zero window still strobes with zero sums
    trig(0, 0);
    push_exp(0, 0);
    drain();

    check_eq("sb_final", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
